// File: rtl/bitwise_resp.sv
// bitwise_resp: valid/ready responder computing AND/OR/XOR on operand pairs.
// A two-stage pipeline feeds a small in-order result FIFO. Admission is
// credit based: anything already in the pipeline holds a FIFO slot, so the
// pipeline never stalls and a push always finds room.
module bitwise_resp #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_err,
  output logic [CNT_W-1:0] done_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W  = $clog2(DEPTH + 3);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  // Result packing: {err, result}. Reserved op yields zero with err set.
  function automatic logic [WIDTH:0] bitwise_op(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic [WIDTH:0] r;
    case (op)
      2'b00:   r = {1'b0, a & b};
      2'b01:   r = {1'b0, a | b};
      2'b10:   r = {1'b0, a ^ b};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  logic             rdy_en;
  logic             accept;
  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ;

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [1:0]       op_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] res_p2;
  logic             err_p2;

  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic [WIDTH:0]   head;

  // Credit-based admission from registered state only; rdy_en keeps
  // in_ready low until the first clock edge after reset release.
  always_comb begin
    occ      = OCC_W'(fifo_cnt) + OCC_W'(vld_p1) + OCC_W'(vld_p2);
    in_ready = rdy_en && (occ < DEPTH_OCC);
    accept   = in_valid && in_ready;
    push     = vld_p2;
    pop      = out_valid && out_ready;
  end

  // Pipeline valids and the ready-enable flag (control, async reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 1: capture operands on an accepted transfer.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1  <= in_a;
      b_p1  <= in_b;
      op_p1 <= in_op;
    end
  end

  // Stage 2: compute result and error flag from stage 1.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      {err_p2, res_p2} <= bitwise_op(a_p1, b_p1, op_p1);
    end
  end

  // FIFO storage: push stage 2 into the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {err_p2, res_p2};
    end
  end

  // FIFO pointers and occupancy count; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Delivered-result counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= '0;
    end else if (pop) begin
      done_count <= done_count + CNT_W'(1);
    end
  end

  // Show-ahead head; outputs forced to zero while the FIFO is empty so
  // reset and idle present clean values without resetting storage.
  always_comb begin
    head       = mem[rd_ptr];
    out_valid  = (fifo_cnt != '0);
    out_result = out_valid ? head[WIDTH-1:0] : '0;
    out_err    = out_valid && head[WIDTH];
  end

endmodule

// File: tb/tb_bitwise_resp.sv
// Bench for bitwise_resp: randomized and directed operand traffic with a
// queue-based scoreboard and an independent transaction-level model.
module tb_bitwise_resp;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic          out_err;
  logic [CW-1:0] done_count;

  bitwise_resp #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .done_count (done_count)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           rdy;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   acc_total;
  int   del_total;
  bit   armed;
  bit   rnd_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour straight from the operation table.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input int rdy);
    exp_t e;
    e.rdy = rdy;
    e.err = 1'b0;
    case (op)
      2'd0:    e.res = a & b;
      2'd1:    e.res = a | b;
      2'd2:    e.res = a ^ b;
      default: begin e.res = '0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Edge counter and "one edge seen since release" flag.
  always @(posedge clk) begin
    cyc++;
    if (rst_n) armed = 1'b1;
  end

  // Monitor: sampled at the falling edge, predicts the next rising edge.
  exp_t mon_e;
  logic mon_ev;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_ev = (sb.size() > 0) && (sb[0].rdy <= cyc);
      check("in_ready", 32'(in_ready), 32'(armed && ((acc_total - del_total) < DEPTH)));
      check("out_valid", 32'(out_valid), 32'(mon_ev));
      check("done_count", 32'(done_count), 32'(del_total[CW-1:0]));
      if (out_valid && mon_ev) begin
        mon_e = sb[0];
        check("out_result", 32'(out_result), 32'(mon_e.res));
        check("out_err", 32'(out_err), 32'(mon_e.err));
        if (out_ready) begin
          void'(sb.pop_front());
          del_total++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_op, cyc + 3));
        acc_total++;
      end
    end
  end

  task automatic clear_model();
    armed = 1'b0;
    sb.delete();
    acc_total = 0;
    del_total = 0;
  endtask

  // Offer one operand pair until accepted (bounded).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_a  = W'($urandom);
    in_b  = W'($urandom);
    in_op = 2'($urandom);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted (t=%0t)", $time);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    acc_total = 0; del_total = 0; armed = 1'b0; rnd_done = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 4'hF; in_b = 4'hF; in_op = 2'b00; out_ready = 1'b0;
    #1 rst_n = 1'b0;

    // Reset behaviour with in_valid held high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_done_count", 32'(done_count), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rel_in_ready_post_edge", 32'(in_ready), 32'd1);
    check("rel_nothing_accepted", 32'(out_valid), 32'd0);

    // Single AND.
    out_ready = 1'b1;
    send(4'b1100, 4'b1010, 2'b00);
    drain();
    check("single_done_count", 32'(done_count), 32'd1);

    // Streaming OR / XOR / reserved.
    send(4'b0101, 4'b0011, 2'b01);
    send(4'b0101, 4'b0011, 2'b10);
    send(4'b0101, 4'b0011, 2'b11);
    drain();
    check("stream_done_count", 32'(done_count), 32'd4);

    // Backpressure: fill to capacity, fifth operand must wait.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(W'(i), 4'b0000, 2'b10);
    in_a = 4'b0101; in_b = 4'b0000; in_op = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'b0101, 4'b0000, 2'b10);
    drain();

    // Reset mid-operation: 3 queued + 1 in flight.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(W'(i), 4'b0000, 2'b10);
    @(posedge clk); #1;
    check("mid_pre_out_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    check("mid_async_out_valid", 32'(out_valid), 32'd0);
    check("mid_async_out_result", 32'(out_result), 32'd0);
    check("mid_async_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_post_out_valid", 32'(out_valid), 32'd0);
    end
    send(4'b1111, 4'b0110, 2'b00);
    drain();

    // Randomized traffic with random consumer backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(W'($urandom), W'($urandom), 2'($urandom));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Counter wrap: 255 then 0 after the 256th delivery.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 255; i++) send(W'($urandom), W'($urandom), 2'($urandom));
    drain();
    check("wrap_255", 32'(done_count), 32'd255);
    send(4'b1010, 4'b0110, 2'b10);
    drain();
    check("wrap_0", 32'(done_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
